mem_access_unit: RTL and testbench

Parametrised successor to the fixed MAR/MDR/RAM path. Holds MAR and MDR. Runs a handshaked read/write sequencer toward a memory with variable latency, in place of a single-cycle wren/q RAM. Sits between the datapath bus (loads MAR/MDR, drives MDR onto the bus mux) and the memory port. Reports busy/done to the control unit.

---
 rtl/mem_access_pkg.sv | 24 ++
 rtl/mem_access_if.sv | 32 +++
 rtl/mem_access_fsm.sv | 120 ++++++++++++
 rtl/mem_access_unit.sv | 110 +++++++++++
 tb/tb_mem_access_unit.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_pkg
// Shared types and constants for the memory access unit: sequencer state
// encoding, default widths and the wait-counter width helper.
// -----------------------------------------------------------------------------
package mem_access_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_DATA_W         = 32;
  localparam int DEF_ADDR_W         = 9;
  localparam int DEF_TIMEOUT_CYCLES = 64;

  // Counter must be able to hold the limit value itself.
  function automatic int tmo_cnt_w(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// -----------------------------------------------------------------------------
// mem_access_if
// Memory-side request/response port of the memory access unit.
//   mem_req   : request, held until mem_ready
//   mem_we    : 1 = write, 0 = read (valid while mem_req)
//   mem_addr  : word address (valid while mem_req)
//   mem_wdata : write data (valid while mem_req)
//   mem_rdata : read data, valid when mem_ready
//   mem_ready : memory accepts/completes the current request this cycle
// master = access unit side, slave = memory side.
// -----------------------------------------------------------------------------
interface mem_access_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mem_access_fsm.sv
// -----------------------------------------------------------------------------
// mem_access_fsm
// Read/write sequencer: IDLE -> READ/WRITE -> DONE -> IDLE.
// Generates mem_req, busy, the one-cycle done pulse and (optionally) the
// timeout err pulse.
// Optional feature macro: MEM_TIMEOUT_EN (wait-state limit of TIMEOUT_CYCLES).
// Ports:
//   clock, clear_n   : clock, synchronous active-low reset
//   i_rd_start       : start read (IDLE only, wins over i_wr_start)
//   i_wr_start       : start write (IDLE only)
//   i_mem_ready      : memory completion, looked at only in READ/WRITE
//   o_state          : current state, used by the top for register control
//   o_busy, o_done, o_err, o_mem_req : registered status/request outputs
// -----------------------------------------------------------------------------
module mem_access_fsm
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic   clock,
  input  logic   clear_n,
  input  logic   i_rd_start,
  input  logic   i_wr_start,
  input  logic   i_mem_ready,
  output state_t o_state,
  output logic   o_busy,
  output logic   o_done,
  output logic   o_err,
  output logic   o_mem_req
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  state_t r_state;
  logic   r_busy;
  logic   r_done;
  logic   r_err;
  logic   r_mem_req;
  logic   w_timeout;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = tmo_cnt_w(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0] w_cnt_next;

  assign w_cnt_next = r_wait_cnt + CNT_W'(1);
  // mem_ready on the limit cycle wins: timeout only fires on a non-ready cycle.
  assign w_timeout  = !i_mem_ready && (w_cnt_next == CNT_W'(TIMEOUT_CYCLES));

  // Counter sits at zero outside READ/WRITE, so it is clear on entry.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      r_wait_cnt <= '0;
    end else if ((r_state == READ || r_state == WRITE) && !i_mem_ready) begin
      r_wait_cnt <= w_cnt_next;
    end else begin
      r_wait_cnt <= '0;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      r_state   <= IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_mem_req <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_rd_start) begin
            r_state   <= READ;
            r_busy    <= 1'b1;
            r_mem_req <= 1'b1;
          end else if (i_wr_start) begin
            r_state   <= WRITE;
            r_busy    <= 1'b1;
            r_mem_req <= 1'b1;
          end
        end
        READ, WRITE: begin
          if (i_mem_ready) begin
            r_state   <= DONE;
            r_mem_req <= 1'b0;
            r_done    <= 1'b1;
          end else if (w_timeout) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_mem_req <= 1'b0;
            r_err     <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state   <= IDLE;
          r_busy    <= 1'b0;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign o_state   = r_state;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_err     = r_err;
  assign o_mem_req = r_mem_req;

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// MAR/MDR registers plus a handshaked sequencer toward a variable-latency
// memory. The datapath loads MAR/MDR from the bus; the control unit starts
// reads/writes and watches busy/done.
// Optional feature macro: MEM_TIMEOUT_EN (err pulse after TIMEOUT_CYCLES
// wait states; otherwise err is always 0 and the unit waits indefinitely).
// Ports:
//   clock, clear_n          : clock, synchronous active-low reset
//   bus_in                  : datapath bus
//   MAR_enable / MDR_enable : load MAR / MDR from bus_in (only when not busy)
//   rd_start / wr_start     : start pulses (ignored while busy, read wins)
//   MAR_q / MDR_q           : register contents
//   busy / done / err       : sequencer status
//   mem                     : memory port (mem_access_if.master)
// -----------------------------------------------------------------------------
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int DATA_W         = DEF_DATA_W,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              MAR_enable,
  input  logic              MDR_enable,
  input  logic              rd_start,
  input  logic              wr_start,
  output logic [DATA_W-1:0] MAR_q,
  output logic [DATA_W-1:0] MDR_q,
  output logic              busy,
  output logic              done,
  output logic              err,
  mem_access_if.master      mem
);

  logic [DATA_W-1:0] r_mar;
  logic [DATA_W-1:0] r_mdr;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  state_t w_state;
  logic   w_busy;
  logic   w_launch_rd;
  logic   w_launch_wr;
  logic   w_rd_capture;

  mem_access_fsm #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_fsm (
    .clock       (clock),
    .clear_n     (clear_n),
    .i_rd_start  (rd_start),
    .i_wr_start  (wr_start),
    .i_mem_ready (mem.mem_ready),
    .o_state     (w_state),
    .o_busy      (w_busy),
    .o_done      (done),
    .o_err       (err),
    .o_mem_req   (mem.mem_req)
  );

  assign w_launch_rd  = (w_state == IDLE) && rd_start;
  assign w_launch_wr  = (w_state == IDLE) && wr_start && !rd_start;
  assign w_rd_capture = (w_state == READ) && mem.mem_ready;

  // NOTE: non-blocking assignments make a same-cycle start and MAR/MDR load
  // launch with the old register value while the load still lands.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      r_mar       <= '0;
      r_mdr       <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      if (MAR_enable && !w_busy) begin
        r_mar <= bus_in;
      end

      // A read completion always overrides a bus load of MDR.
      if (w_rd_capture) begin
        r_mdr <= mem.mem_rdata;
      end else if (MDR_enable && !w_busy) begin
        r_mdr <= bus_in;
      end

      // Memory port fields change only at launch, so they hold through waits.
      if (w_launch_rd) begin
        r_mem_we   <= 1'b0;
        r_mem_addr <= r_mar[ADDR_W-1:0];
      end else if (w_launch_wr) begin
        r_mem_we    <= 1'b1;
        r_mem_addr  <= r_mar[ADDR_W-1:0];
        r_mem_wdata <= r_mdr;
      end
    end
  end

  assign MAR_q         = r_mar;
  assign MDR_q         = r_mdr;
  assign busy          = w_busy;
  assign mem.mem_we    = r_mem_we;
  assign mem.mem_addr  = r_mem_addr;
  assign mem.mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
// Directed tests for mem_access_unit. Inputs change and outputs are sampled
// on the falling clock edge. Built with MEM_TIMEOUT_EN, the timeout tests run;
// otherwise the indefinite-wait test runs.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 9;
  localparam int TMO    = 4;

  logic              clock = 1'b0;
  logic              clear_n;
  logic [DATA_W-1:0] bus_in;
  logic              MAR_enable;
  logic              MDR_enable;
  logic              rd_start;
  logic              wr_start;
  logic [DATA_W-1:0] MAR_q;
  logic [DATA_W-1:0] MDR_q;
  logic              busy;
  logic              done;
  logic              err;

  int n_total = 0;
  int n_bad   = 0;

  mem_access_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) mem_if ();

  mem_access_unit #(
    .DATA_W         (DATA_W),
    .ADDR_W         (ADDR_W),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock      (clock),
    .clear_n    (clear_n),
    .bus_in     (bus_in),
    .MAR_enable (MAR_enable),
    .MDR_enable (MDR_enable),
    .rd_start   (rd_start),
    .wr_start   (wr_start),
    .MAR_q      (MAR_q),
    .MDR_q      (MDR_q),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .mem        (mem_if.master)
  );

  always #5 clock = ~clock;

  // Status bits in order busy, done, err, mem_req, mem_we.
  logic [4:0] flags;
  assign flags = {busy, done, err, mem_if.mem_req, mem_if.mem_we};

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    bus_in     = '0;
    MAR_enable = 1'b0;
    MDR_enable = 1'b0;
    rd_start   = 1'b0;
    wr_start   = 1'b0;
    mem_if.mem_ready = 1'b0;
    mem_if.mem_rdata = '0;
  endtask

  task automatic test_reset();
    clear_n    = 1'b0;
    bus_in     = '1;
    MAR_enable = 1'b1;
    MDR_enable = 1'b1;
    rd_start   = 1'b1;
    wr_start   = 1'b1;
    mem_if.mem_ready = 1'b1;
    mem_if.mem_rdata = '1;
    step();
    n_total++; if (flags !== 5'b00000) begin n_bad++; $display("FAIL reset_flags(busy,done,err,req,we): got %b want %b", flags, 5'b00000); end
    n_total++; if ({MAR_q, MDR_q} !== 64'h0) begin n_bad++; $display("FAIL reset_mar_mdr: got %h want 0", {MAR_q, MDR_q}); end
    n_total++; if ({mem_if.mem_addr, mem_if.mem_wdata} !== 41'h0) begin n_bad++; $display("FAIL reset_mem_port: got %h want 0", {mem_if.mem_addr, mem_if.mem_wdata}); end
    idle_inputs();
    clear_n = 1'b1;
    step();
  endtask

  task automatic test_zero_wait_read();
    bus_in = 32'h0000_0012; MAR_enable = 1'b1;
    step();
    n_total++; if (MAR_q !== 32'h0000_0012) begin n_bad++; $display("FAIL mar_load: got %h want %h", MAR_q, 32'h0000_0012); end
    // Ready already high in the IDLE cycle: must be ignored until mem_req.
    MAR_enable = 1'b0; rd_start = 1'b1;
    mem_if.mem_ready = 1'b1; mem_if.mem_rdata = 32'hDEAD_BEEF;
    step();
    rd_start = 1'b0;
    n_total++; if (flags !== 5'b10010) begin n_bad++; $display("FAIL rd0_req_flags: got %b want %b", flags, 5'b10010); end
    n_total++; if (mem_if.mem_addr !== 9'h012) begin n_bad++; $display("FAIL rd0_addr: got %h want %h", mem_if.mem_addr, 9'h012); end
    n_total++; if (MDR_q !== 32'h0) begin n_bad++; $display("FAIL rd0_mdr_early: got %h want 0", MDR_q); end
    step();
    n_total++; if (flags !== 5'b11000) begin n_bad++; $display("FAIL rd0_done_flags: got %b want %b", flags, 5'b11000); end
    n_total++; if (MDR_q !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rd0_mdr: got %h want %h", MDR_q, 32'hDEAD_BEEF); end
    mem_if.mem_ready = 1'b0;
    step();
    n_total++; if (flags[4:3] !== 2'b00) begin n_bad++; $display("FAIL rd0_idle(busy,done): got %b want 00", flags[4:3]); end
  endtask

  task automatic test_write_wait();
    bus_in = 32'h1234_5678; MDR_enable = 1'b1;
    step();
    MDR_enable = 1'b0; bus_in = 32'h0000_01FF; MAR_enable = 1'b1;
    step();
    MAR_enable = 1'b0; wr_start = 1'b1;
    mem_if.mem_rdata = 32'h0F0F_0F0F;
    step();
    wr_start = 1'b0;
    // MDR load attempt during WRITE must be ignored.
    MDR_enable = 1'b1; bus_in = 32'h0000_00AA;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if ({flags, mem_if.mem_addr, mem_if.mem_wdata} !== {5'b10011, 9'h1FF, 32'h1234_5678}) begin
        n_bad++;
        $display("FAIL wr_hold%0d(flags,addr,wdata): got %b %h %h want 10011 1ff 12345678",
                 i, flags, mem_if.mem_addr, mem_if.mem_wdata);
      end
      if (i == 3) mem_if.mem_ready = 1'b1;
      step();
    end
    MDR_enable = 1'b0; mem_if.mem_ready = 1'b0;
    n_total++; if (flags[4:1] !== 4'b1100) begin n_bad++; $display("FAIL wr_done(busy,done,err,req): got %b want 1100", flags[4:1]); end
    n_total++; if (MDR_q !== 32'h1234_5678) begin n_bad++; $display("FAIL wr_mdr_kept: got %h want %h", MDR_q, 32'h1234_5678); end
    step();
    n_total++; if (flags[4:3] !== 2'b00) begin n_bad++; $display("FAIL wr_single_done(busy,done): got %b want 00", flags[4:3]); end
  endtask

  task automatic test_conflicts();
    rd_start = 1'b1; wr_start = 1'b1; mem_if.mem_rdata = 32'hCAFE_F00D;
    step();
    rd_start = 1'b0; wr_start = 1'b0;
    n_total++; if (flags !== 5'b10010) begin n_bad++; $display("FAIL rdwr_read_wins: got %b want %b", flags, 5'b10010); end
    MAR_enable = 1'b1; bus_in = 32'h0000_00AA;
    step();
    MAR_enable = 1'b0;
    n_total++; if ({MAR_q, mem_if.mem_addr} !== {32'h0000_01FF, 9'h1FF}) begin n_bad++; $display("FAIL mar_busy_hold: got %h %h want 1ff 1ff", MAR_q, mem_if.mem_addr); end
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    n_total++; if (flags !== 5'b10010) begin n_bad++; $display("FAIL rd_during_read: got %b want %b", flags, 5'b10010); end
    // Capture must win over an MDR bus load on the completion edge.
    mem_if.mem_ready = 1'b1; MDR_enable = 1'b1; bus_in = 32'h0000_0055;
    step();
    mem_if.mem_ready = 1'b0; MDR_enable = 1'b0;
    n_total++; if ({done, MDR_q} !== {1'b1, 32'hCAFE_F00D}) begin n_bad++; $display("FAIL rd_capture_wins: got %b %h want 1 cafef00d", done, MDR_q); end
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    n_total++; if (flags !== 5'b00000) begin n_bad++; $display("FAIL start_in_done_ignored: got %b want 00000", flags); end
    step();
    n_total++; if (flags !== 5'b00000) begin n_bad++; $display("FAIL start_not_queued: got %b want 00000", flags); end
  endtask

  task automatic test_same_cycle_load();
    MAR_enable = 1'b1; bus_in = 32'h0000_0203; rd_start = 1'b1;
    step();
    MAR_enable = 1'b0; rd_start = 1'b0;
    n_total++; if ({MAR_q, mem_if.mem_addr} !== {32'h0000_0203, 9'h1FF}) begin n_bad++; $display("FAIL same_cycle_load(mar,addr): got %h %h want 203 1ff", MAR_q, mem_if.mem_addr); end
    mem_if.mem_ready = 1'b1; mem_if.mem_rdata = 32'h600D_600D;
    step();
    mem_if.mem_ready = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    int n_done;
    n_done = 0;
    rd_start = 1'b1; mem_if.mem_ready = 1'b1; mem_if.mem_rdata = 32'h1122_3344;
    for (int i = 0; i < 9; i++) begin
      step();
      if (i == 8) begin rd_start = 1'b0; mem_if.mem_ready = 1'b0; end
      if (done) n_done++;
      n_total++;
      if (done !== (i % 3 == 1)) begin n_bad++; $display("FAIL b2b_done%0d: got %b want %b", i, done, (i % 3 == 1)); end
      if (i % 3 == 0) begin
        // Upper MAR bits are dropped: 0x203 -> address 0x003.
        n_total++;
        if ({mem_if.mem_req, mem_if.mem_addr} !== {1'b1, 9'h003}) begin n_bad++; $display("FAIL b2b_req%0d(req,addr): got %b %h want 1 003", i, mem_if.mem_req, mem_if.mem_addr); end
      end
    end
    n_total++; if (n_done !== 3) begin n_bad++; $display("FAIL b2b_done_count: got %0d want 3", n_done); end
    step();
    n_total++; if ({busy, MDR_q} !== {1'b0, 32'h1122_3344}) begin n_bad++; $display("FAIL b2b_end(busy,mdr): got %b %h want 0 11223344", busy, MDR_q); end
  endtask

  task automatic test_reset_mid_read();
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    step();
    step();
    clear_n = 1'b0; mem_if.mem_ready = 1'b1; mem_if.mem_rdata = 32'hFFFF_0000;
    step();
    n_total++; if (flags !== 5'b00000) begin n_bad++; $display("FAIL midrst_flags: got %b want 00000", flags); end
    n_total++; if ({MAR_q, MDR_q, mem_if.mem_addr} !== 73'h0) begin n_bad++; $display("FAIL midrst_regs: got %h %h %h want 0", MAR_q, MDR_q, mem_if.mem_addr); end
    clear_n = 1'b1; mem_if.mem_ready = 1'b0;
    step();
    n_total++; if ({flags, MDR_q} !== {5'b00000, 32'h0}) begin n_bad++; $display("FAIL midrst_after: got %b %h want 00000 0", flags, MDR_q); end
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    MDR_enable = 1'b1; bus_in = 32'h0BAD_F00D;
    step();
    MDR_enable = 1'b0; rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      n_total++;
      if (flags !== 5'b10010) begin n_bad++; $display("FAIL tmo_wait%0d: got %b want 10010", i, flags); end
      step();
    end
    n_total++; if ({flags, MDR_q} !== {5'b00100, 32'h0BAD_F00D}) begin n_bad++; $display("FAIL tmo_err: got %b %h want 00100 0badf00d", flags, MDR_q); end
    step();
    n_total++; if (flags !== 5'b00000) begin n_bad++; $display("FAIL tmo_err_pulse: got %b want 00000", flags); end
    // Ready on the limit cycle counts as success.
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    repeat (TMO - 1) step();
    mem_if.mem_ready = 1'b1; mem_if.mem_rdata = 32'h5A5A_5A5A;
    step();
    mem_if.mem_ready = 1'b0;
    n_total++; if ({flags, MDR_q} !== {5'b11000, 32'h5A5A_5A5A}) begin n_bad++; $display("FAIL tmo_limit_ready: got %b %h want 11000 5a5a5a5a", flags, MDR_q); end
    step();
  endtask
`else
  task automatic test_no_timeout();
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      n_total++;
      if (flags !== 5'b10010) begin n_bad++; $display("FAIL notmo_wait%0d: got %b want 10010", i, flags); end
    end
    mem_if.mem_ready = 1'b1; mem_if.mem_rdata = 32'h7777_0001;
    step();
    mem_if.mem_ready = 1'b0;
    n_total++; if ({flags, MDR_q} !== {5'b11000, 32'h7777_0001}) begin n_bad++; $display("FAIL notmo_done: got %b %h want 11000 77770001", flags, MDR_q); end
    step();
  endtask
`endif

  initial begin
    idle_inputs();
    clear_n = 1'b0;
    test_reset();
    test_zero_wait_read();
    test_write_wait();
    test_conflicts();
    test_same_cycle_load();
    test_back_to_back();
    test_reset_mid_read();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
